// File: rtl/des_pkg.sv
// rtl/des_pkg.sv - DES tables, widths, state type and permutation helpers shared by the DES cores
package des_pkg;
  localparam int BLOCK_W  = 64;
  localparam int HALF_W   = 32;
  localparam int KEY56_W  = 56;
  localparam int SUBKEY_W = 48;

  typedef enum logic [1:0] {IDLE, ROUND, DONE} des_state_t;

  // Tables use DES 1-based bit numbers; bit 0 of every vector is DES bit 1.
  localparam int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

  localparam int IP_INV_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};

  localparam int E_T [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
     8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

  localparam int P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};

  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};

  // Right-rotation applied after round n (index n) when walking K16 down to K1.
  localparam int RS_T [16] = '{0, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  // Indexed by {b1, b6, b2..b5}, i.e. row*16 + column.
  localparam int SBOX_T [8][64] = '{
    '{14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7,
       0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
       4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0,
      15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13},
    '{15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10,
       3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
       0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15,
      13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9},
    '{10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8,
      13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
      13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7,
       1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12},
    '{ 7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15,
      13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
      10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4,
       3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14},
    '{ 2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9,
      14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
       4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14,
      11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3},
    '{12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11,
      10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
       9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6,
       4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13},
    '{ 4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1,
      13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
       1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2,
       6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12},
    '{13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7,
       1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
       7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8,
       2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11}};

  function automatic logic [0:BLOCK_W-1] ip_perm(input logic [0:BLOCK_W-1] x);
    logic [0:BLOCK_W-1] y;
    for (int i = 0; i < BLOCK_W; i++) y[i] = x[IP_T[i] - 1];
    return y;
  endfunction

  function automatic logic [0:BLOCK_W-1] ip_inv_perm(input logic [0:BLOCK_W-1] x);
    logic [0:BLOCK_W-1] y;
    for (int i = 0; i < BLOCK_W; i++) y[i] = x[IP_INV_T[i] - 1];
    return y;
  endfunction

  function automatic logic [0:SUBKEY_W-1] e_expand(input logic [0:HALF_W-1] x);
    logic [0:SUBKEY_W-1] y;
    for (int i = 0; i < SUBKEY_W; i++) y[i] = x[E_T[i] - 1];
    return y;
  endfunction

  function automatic logic [0:HALF_W-1] p_perm(input logic [0:HALF_W-1] x);
    logic [0:HALF_W-1] y;
    for (int i = 0; i < HALF_W; i++) y[i] = x[P_T[i] - 1];
    return y;
  endfunction

  function automatic logic [0:KEY56_W-1] pc1_perm(input logic [0:BLOCK_W-1] x);
    logic [0:KEY56_W-1] y;
    for (int i = 0; i < KEY56_W; i++) y[i] = x[PC1_T[i] - 1];
    return y;
  endfunction

  function automatic logic [0:SUBKEY_W-1] pc2_perm(input logic [0:KEY56_W-1] x);
    logic [0:SUBKEY_W-1] y;
    for (int i = 0; i < SUBKEY_W; i++) y[i] = x[PC2_T[i] - 1];
    return y;
  endfunction
endpackage

// File: rtl/des_feistel_f.sv
// rtl/des_feistel_f.sv - combinational DES round function f(R, K): expand, key mix, S-boxes, P
module des_feistel_f
  import des_pkg::*;
(
  input  logic [0:HALF_W-1]   r,
  input  logic [0:SUBKEY_W-1] k,
  output logic [0:HALF_W-1]   f
);
  logic [0:SUBKEY_W-1] x;
  logic [0:HALF_W-1]   s_out;
  logic [0:5]          b;

  always_comb begin
    x     = e_expand(r) ^ k;
    s_out = '0;
    b     = '0;
    for (int i = 0; i < 8; i++) begin
      b = x[6*i +: 6];
      s_out[4*i +: 4] = 4'(SBOX_T[i][{b[0], b[5], b[1:4]}]);
    end
    f = p_perm(s_out);
  end
endmodule

// File: rtl/des_decrypt_core.sv
// rtl/des_decrypt_core.sv - iterative DES decryptor, one Feistel round per clock, valid/ready on both sides
module des_decrypt_core
  import des_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [0:BLOCK_W-1]  key,
  input  logic [0:BLOCK_W-1]  data_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [0:BLOCK_W-1]  data_out,
  output logic                busy
);
  des_state_t          state, state_nxt;
  logic [3:0]          cnt;
  logic [3:0]          rs_idx;
  logic [0:HALF_W-1]   l, r, f_out, r_round;
  logic [0:27]         c, d, c_rot, d_rot;
  logic [0:SUBKEY_W-1] subkey;

  assign subkey  = pc2_perm({c, d});
  assign r_round = l ^ f_out;
  // Wraps to 0 on the last round, where the rotation is irrelevant.
  assign rs_idx  = cnt + 4'd1;

  des_feistel_f u_feistel_f (
    .r (r),
    .k (subkey),
    .f (f_out)
  );

  always_comb begin
    c_rot = c;
    d_rot = d;
    if (RS_T[rs_idx] == 1) begin
      c_rot = {c[27], c[0:26]};
      d_rot = {d[27], d[0:26]};
    end else if (RS_T[rs_idx] == 2) begin
      c_rot = {c[26:27], c[0:25]};
      d_rot = {d[26:27], d[0:25]};
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = ROUND;
      end
      ROUND: begin
        busy = 1'b1;
        if (cnt == 4'd15) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      l        <= '0;
      r        <= '0;
      c        <= '0;
      d        <= '0;
      data_out <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (in_valid) begin
            {l, r} <= ip_perm(data_in);
            {c, d} <= pc1_perm(key);
            cnt    <= '0;
          end
        end
        ROUND: begin
          l   <= r;
          r   <= r_round;
          c   <= c_rot;
          d   <= d_rot;
          cnt <= cnt + 4'd1;
          // Output takes the swapped halves {R16, L16} of the final round.
          if (cnt == 4'd15) data_out <= ip_inv_perm({r_round, r});
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_des_decrypt_core.sv
// tb/tb_des_decrypt_core.sv - scoreboard bench for des_decrypt_core
module tb_des_decrypt_core;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        in_ready, out_valid, busy;
  logic [0:63] key = '0;
  logic [0:63] data_in = '0;
  logic [0:63] data_out;
  logic [0:63] exp_q [$];
  int          cyc = 0;
  int          vectors = 0;
  int          miscompares = 0;
  int          t1, t2;

  localparam logic [0:63] K1 = 64'h133457799BBCDFF1;
  localparam logic [0:63] C1 = 64'h85E813540F0AB405;
  localparam logic [0:63] P1 = 64'h0123456789ABCDEF;
  localparam logic [0:63] K2 = 64'h0E329232EA6D0D73;
  localparam logic [0:63] C2 = 64'h0000000000000000;
  localparam logic [0:63] P2 = 64'h8787878787878787;
  localparam logic [0:63] K3 = 64'h123556789ABDDEF0;

  des_decrypt_core dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .key       (key),
    .data_in   (data_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [0:63] k, input logic [0:63] ct, input logic [0:63] pt);
    key      = k;
    data_in  = ct;
    in_valid = 1'b1;
    exp_q.push_back(pt);
  endtask

  task automatic scramble();
    in_valid = 1'b0;
    key      = {$urandom, $urandom};
    data_in  = {$urandom, $urandom};
  endtask

  task automatic wait_accept(output int t);
    int n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("accept_timeout", 64'(in_ready), 64'd1);
    @(negedge clk);
    t = cyc;
  endtask

  task automatic wait_out(input int t_acc, input string tag);
    int          n = 0;
    logic [0:63] e;
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_timeout"}, 64'(out_valid), 64'd1);
    chk({tag, "_latency"}, 64'(cyc - t_acc), 64'd16);
    if (exp_q.size() != 0) e = exp_q.pop_front();
    else e = 'x;
    chk(tag, data_out, e);
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("release_in_ready", 64'(in_ready), 64'd1);
    chk("release_out_valid", 64'(out_valid), 64'd0);
    chk("release_busy", 64'(busy), 64'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_data_out", data_out, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    drive(K1, C1, P1);
    wait_accept(t1);
    scramble();
    wait_out(t1, "basic");
    chk("basic_busy", 64'(busy), 64'd1);
    chk("basic_in_ready", 64'(in_ready), 64'd0);
    release_out();
    chk("keep_data_out", data_out, P1);

    drive(K2, C2, P2);
    wait_accept(t1);
    scramble();
    wait_out(t1, "zero_ct");
    release_out();

    drive(K3, C1, P1);
    wait_accept(t1);
    scramble();
    wait_out(t1, "parity");
    release_out();

    drive(K2, C2, P2);
    wait_accept(t1);
    scramble();
    wait_out(t1, "bp");
    for (int i = 0; i < 5; i++) begin
      in_valid = ~in_valid;
      key      = {$urandom, $urandom};
      data_in  = {$urandom, $urandom};
      @(negedge clk);
      chk("bp_stable", data_out, P2);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_out_valid", 64'(out_valid), 64'd1);
    end
    in_valid = 1'b0;
    release_out();

    out_ready = 1'b1;
    drive(K1, C1, P1);
    wait_accept(t1);
    drive(K2, C2, P2);
    wait_out(t1, "b2b_first");
    wait_accept(t2);
    chk("b2b_spacing", 64'(t2 - t1), 64'd18);
    scramble();
    wait_out(t2, "b2b_second");
    @(negedge clk);
    out_ready = 1'b0;
    chk("b2b_idle", 64'(in_ready), 64'd1);

    key      = K1;
    data_in  = C1;
    in_valid = 1'b1;
    wait_accept(t1);
    scramble();
    repeat (7) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_data_out", data_out, 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_no_result", 64'(out_valid), 64'd0);

    drive(K1, C1, P1);
    wait_accept(t1);
    scramble();
    wait_out(t1, "after_rst");
    release_out();

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
